// File: rtl/sram_controller_if.sv
// Pipeline-side bus of the SRAM controller.
// Master is the memory stage, slave is the controller.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit memory-stage to 16-bit async SRAM bridge.
// Each word is two halfword beats (low, high) plus fixed padding.
module sram_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 6
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_ADDR,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N,
    output logic             SRAM_WE_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_OE_N
);
    localparam int CW = $clog2(ACCESS_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic [16:0]   wa_q, wa_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   off;
    logic          req;
    logic          dq_oe;
    logic [15:0]   dq_out;

    assign req = bus.wr_en | bus.rd_en;
    assign off = bus.address - 32'(BASE_ADDR);

    // Only the word-index bits of the offset reach the SRAM.
    wire unused_off = &{1'b0, off[31:19], off[1:0]};

    assign bus.ready     = ~req | (state_q == S_DONE);
    assign bus.read_data = rdata_q;
    assign SRAM_DQ       = dq_oe ? dq_out : 16'hzzzz;

    // State and transaction registers; reset returns the bus to idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            wa_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: accept in IDLE, two beats, padding, one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        wa_d    = wa_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    is_wr_d = bus.wr_en;
                    wa_d    = off[18:2];
                    wdata_d = bus.write_data;
                    state_d = S_LO;
                end
            end
            S_LO: state_d = S_HI;
            S_HI: begin
                if (ACCESS_CYCLES > 4) begin
                    cnt_d   = CW'(ACCESS_CYCLES - 4);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read capture: low half at the end of LO, high half at the end of HI.
    always_comb begin
        rdata_d = rdata_q;
        if (!is_wr_q && state_q == S_LO) begin
            rdata_d[15:0] = SRAM_DQ;
        end
        if (!is_wr_q && state_q == S_HI) begin
            rdata_d[31:16] = SRAM_DQ;
        end
    end

    // SRAM pins: active only during the two beats, parked otherwise.
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        if (state_q == S_LO || state_q == S_HI) begin
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_WE_N = ~is_wr_q;
            SRAM_OE_N = is_wr_q;
            SRAM_ADDR = {wa_q, state_q == S_HI};
            dq_oe     = is_wr_q;
            dq_out    = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural SRAM.
// Second instance covers the ACCESS_CYCLES=4 variant.
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [17:0] a;
        logic        we_n;
        logic [15:0] dq;
    } beat_t;

    logic [31:0] exp_q[$];
    beat_t       beat_q[$];

    // Main instance, default parameters
    sram_controller_if bus();
    wire  [15:0] dq;
    logic [17:0] s_addr;
    logic s_ub_n, s_lb_n, s_we_n, s_ce_n, s_oe_n;
    logic [15:0] mem [0:63];

    sram_controller u_dut (
        .clk(clk), .rst(rst_n), .bus(bus.slave),
        .SRAM_DQ(dq), .SRAM_ADDR(s_addr),
        .SRAM_UB_N(s_ub_n), .SRAM_LB_N(s_lb_n), .SRAM_WE_N(s_we_n),
        .SRAM_CE_N(s_ce_n), .SRAM_OE_N(s_oe_n)
    );

    assign dq = (!s_ce_n && !s_oe_n) ? mem[s_addr[5:0]] : 16'hzzzz;
    always @(posedge clk)
        if (!s_ce_n && !s_we_n) mem[s_addr[5:0]] <= dq;

    // Variant instance, ACCESS_CYCLES=4
    sram_controller_if bus4();
    wire  [15:0] dq4;
    logic [17:0] s4_addr;
    logic s4_ub_n, s4_lb_n, s4_we_n, s4_ce_n, s4_oe_n;
    logic [15:0] mem4 [0:63];

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst_n), .bus(bus4.slave),
        .SRAM_DQ(dq4), .SRAM_ADDR(s4_addr),
        .SRAM_UB_N(s4_ub_n), .SRAM_LB_N(s4_lb_n), .SRAM_WE_N(s4_we_n),
        .SRAM_CE_N(s4_ce_n), .SRAM_OE_N(s4_oe_n)
    );

    assign dq4 = (!s4_ce_n && !s4_oe_n) ? mem4[s4_addr[5:0]] : 16'hzzzz;
    always @(posedge clk)
        if (!s4_ce_n && !s4_we_n) mem4[s4_addr[5:0]] <= dq4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {27'd0, s_ce_n, s_ub_n, s_lb_n, s_we_n, s_oe_n};
    endfunction

    task automatic push_beat(input logic [17:0] a, input logic we_n, input logic [15:0] d);
        beat_t b;
        b.a = a;
        b.we_n = we_n;
        b.dq = d;
        beat_q.push_back(b);
    endtask

    // Completion monitor: DONE is the cycle where ready is high with a request.
    int stall = 0;
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            stall = 0;
        end else if (bus.wr_en | bus.rd_en) begin
            if (!bus.ready) begin
                stall = stall + 1;
            end else begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stall_cycles", stall, 32'd5);
                    chk("read_data", bus.read_data, e);
                end
                stall = 0;
            end
        end
    end

    // Bus monitor: every active SRAM cycle must match the next expected beat.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n && !s_ce_n) begin
            if (beat_q.size() == 0) begin
                chk("unexpected_beat", {14'd0, s_addr}, 32'hFFFFFFFF);
            end else begin
                b = beat_q.pop_front();
                chk("beat_addr", {14'd0, s_addr}, {14'd0, b.a});
                chk("beat_ctl", ctl(), {27'd0, 3'b000, b.we_n, ~b.we_n});
                if (!b.we_n) chk("beat_dq", {16'd0, dq}, {16'd0, b.dq});
            end
        end
    end

    task automatic wait_done(input int n);
        int seen = 0;
        for (int c = 0; c < 20 * n && seen < n; c++) begin
            @(negedge clk);
            if (bus.ready) seen++;
        end
        if (seen < n) begin
            miscompares++;
            vectors++;
            $display("FAIL timeout: got %0d completions expected %0d", seen, n);
        end
    endtask

    task automatic acc(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
        exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.address = a;
        bus.write_data = d;
        wait_done(1);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.wr_en = 0; bus.rd_en = 0; bus.address = 0; bus.write_data = 0;
        bus4.wr_en = 0; bus4.rd_en = 0; bus4.address = 0; bus4.write_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_read_data", bus.read_data, 32'd0);
        chk("rst_ctl", ctl(), 32'h1F);
        chk("rst_addr", {14'd0, s_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // write then read at base
        push_beat(18'd0, 1'b0, 16'hBEEF);
        push_beat(18'd1, 1'b0, 16'hDEAD);
        acc(1, 0, 32'd1024, 32'hDEADBEEF, 32'h0);
        push_beat(18'd0, 1'b1, 16'h0);
        push_beat(18'd1, 1'b1, 16'h0);
        acc(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF);

        // second word, then read both
        push_beat(18'd4, 1'b0, 16'h5678);
        push_beat(18'd5, 1'b0, 16'h1234);
        acc(1, 0, 32'd1032, 32'h12345678, 32'hDEADBEEF);
        push_beat(18'd0, 1'b1, 16'h0);
        push_beat(18'd1, 1'b1, 16'h0);
        acc(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF);
        push_beat(18'd4, 1'b1, 16'h0);
        push_beat(18'd5, 1'b1, 16'h0);
        acc(0, 1, 32'd1032, 32'h0, 32'h12345678);

        // both requests: write wins, read_data unchanged
        push_beat(18'd8, 1'b0, 16'h5A5A);
        push_beat(18'd9, 1'b0, 16'hA5A5);
        acc(1, 1, 32'd1040, 32'hA5A55A5A, 32'h12345678);
        push_beat(18'd8, 1'b1, 16'h0);
        push_beat(18'd9, 1'b1, 16'h0);
        acc(0, 1, 32'd1043, 32'h0, 32'hA5A55A5A);

        // idle: parked pins, ready high
        repeat (2) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, bus.ready}, 32'd1);
            chk("idle_ctl", ctl(), 32'h1F);
            chk("idle_addr", {14'd0, s_addr}, 32'd0);
        end

        // held request: three back-to-back 6-cycle accesses
        repeat (3) begin
            exp_q.push_back(32'h12345678);
            push_beat(18'd4, 1'b1, 16'h0);
            push_beat(18'd5, 1'b1, 16'h0);
        end
        @(posedge clk);
        #1;
        bus.rd_en = 1'b1;
        bus.address = 32'd1032;
        wait_done(3);
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;

        // reset during HI of a read
        push_beat(18'd0, 1'b1, 16'h0);
        @(posedge clk);
        #1;
        bus.rd_en = 1'b1;
        bus.address = 32'd1024;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", ctl(), 32'h1F);
        chk("arst_addr", {14'd0, s_addr}, 32'd0);
        chk("arst_read_data", bus.read_data, 32'd0);
        chk("arst_ready", {31'd0, bus.ready}, 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(32'hDEADBEEF);
        push_beat(18'd0, 1'b1, 16'h0);
        push_beat(18'd1, 1'b1, 16'h0);
        rst_n = 1'b1;
        wait_done(1);
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;

        // ACCESS_CYCLES=4: ready high in cycle 4
        @(posedge clk);
        #1;
        bus4.wr_en = 1'b1;
        bus4.address = 32'd1028;
        bus4.write_data = 32'hCAFEF00D;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("v4_wr_ready", {31'd0, bus4.ready}, {31'd0, c == 4});
        end
        @(posedge clk);
        #1;
        bus4.wr_en = 1'b0;
        @(posedge clk);
        #1;
        bus4.rd_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("v4_rd_ready", {31'd0, bus4.ready}, {31'd0, c == 4});
        end
        chk("v4_read_data", bus4.read_data, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        bus4.rd_en = 1'b0;

        repeat (3) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("beat_q_drained", beat_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Bridges the 32-bit memory stage of the pipeline to the 16-bit external SRAM (18-bit halfword address, shared inout data bus, active-low controls).
- Each 32-bit word access becomes two back-to-back halfword accesses, low half first, then the high half.
- A fixed number of padding cycles follows.
- `ready` is the stall signal for the pipeline: it stays low until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0. This value is subtracted from `address` before mapping.
- ACCESS_CYCLES, 6: total cycles per access, counting the request cycle as cycle 1. Minimum 4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request; held stable by the pipeline while `ready`=0.
- rd_en  in  1  read request; held stable while `ready`=0.
- address  in  32  byte address; bits [1:0] are ignored.
- write_data  in  32  word to write.
- read_data  out  32  last word read.
- ready  out  1  0 means stall the pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  active-low SRAM controls.

Behaviour:
- Address mapping:
  - off = address - BASE_ADDR, computed modulo 2^32.
  - wa = off[18:2], 17 bits.
  - Low half is at SRAM_ADDR = {wa,1'b0}; high half at {wa,1'b1}.
  - Addresses below BASE_ADDR wrap silently; no error is flagged.
- States: IDLE, LO, HI, WAIT, DONE.
- IDLE:
  - If wr_en|rd_en, latch op, wa and write_data, then go to LO.
  - If both requests are asserted, the access is a write.
- LO: go to HI after 1 cycle.
- HI:
  - If ACCESS_CYCLES>4, go to WAIT with the counter loaded to ACCESS_CYCLES-4.
  - Otherwise go to DONE.
- WAIT: decrement the counter; go to DONE when it reaches 1.
- DONE:
  - Go to IDLE unconditionally.
  - A request present in DONE is not accepted; it is sampled again in IDLE on the next cycle.
- Cycle count: request cycle = 1 (IDLE), LO = 2, HI = 3, WAIT = 4..ACCESS_CYCLES-1, DONE = ACCESS_CYCLES.
- ready:
  - ready = ~(wr_en|rd_en) | (state==DONE), combinational.
  - With the default parameters, ready is low for 5 cycles and high in the 6th.
- SRAM controls in LO/HI: CE_N=0, UB_N=0, LB_N=0.
  - Write: WE_N=0, OE_N=1, SRAM_DQ driven with the latched data: [15:0] in LO, [31:16] in HI.
  - Read: WE_N=1, OE_N=0, SRAM_DQ=Z.
- SRAM controls in all other states: CE_N=1, UB_N=1, LB_N=1, WE_N=1, OE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
- The controller never drives SRAM_DQ while WE_N=1.
- Read capture:
  - At the rising edge ending LO: read_data[15:0] <= SRAM_DQ.
  - At the rising edge ending HI: read_data[31:16] <= SRAM_DQ.
  - read_data holds its value until the next read; writes leave it unchanged.
- Request dropped mid-operation: the latched transaction completes fully. ready reads 1 because no request is present.
- Reset:
  - Async assertion forces IDLE, counter 0, read_data 0, all SRAM controls 1, SRAM_ADDR 0, DQ Z.
  - ready then follows its formula.
  - A write interrupted by reset may leave that word partially written; this is acceptable.
- Back-to-back requests: each takes a full ACCESS_CYCLES cycles; there is no overlap and no pipelining.

Test Plan:
- Write then read:
  - Stimulus: wr_en=1, address=1024, write_data=32'hDEADBEEF.
  - Required: ready is low for cycles 1-5 and high in cycle 6.
  - Required: SRAM_ADDR=0 with DQ=16'hBEEF and WE_N=0 in LO; SRAM_ADDR=1 with DQ=16'hDEAD in HI.
  - Then rd_en=1 at the same address: read_data=32'hDEADBEEF when ready rises.
- Two addresses:
  - Stimulus: write 32'h12345678 to address 1032, then read 1024 followed by 1032.
  - Required: the reads return 32'hDEADBEEF and 32'h12345678.
  - Required: the SRAM halfword addresses used for 1032 are 4 and 5.
- Simultaneous requests:
  - Stimulus: wr_en=1 and rd_en=1 together.
  - Required: a write cycle sequence (WE_N=0 in LO/HI); read_data is unchanged.
- Idle and DONE behaviour:
  - Stimulus: no request.
  - Required: ready=1, all SRAM controls 1, DQ=Z.
  - Stimulus: a request held continuously.
  - Required: DONE occurs every 6 cycles, with one IDLE cycle between accesses.
- Reset mid-read:
  - Stimulus: assert rst=0 during HI.
  - Required: outputs go to their idle values immediately, without waiting for a clock edge, and read_data=0.
  - Required: after release, with rd_en held, a fresh 6-cycle access completes.
- Parameter variant: with ACCESS_CYCLES=4, ready goes high in cycle 4 and the FSM never enters WAIT.
